counter_seq_drv: RTL and testbench
==================================

Name: counter_seq_drv

Overview:
Command-driven controller that drives the control inputs of the up/down counter: load, load_en and down. It receives an operation over a valid/ready handshake and moves the counter by loading, stepping up, stepping down or seeking a target value. It watches count and rollover, and reports completion with a done pulse. It sits between the test or control logic and the counter instance, usually wired through the counter interface bundle.

Parameters:
WIDTH, 4, counter width in bits; must match the driven counter.
WRAPW, 8, width of the per-command wrap event counter.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge clk
cmd_op  input  2  0=LOAD, 1=STEP_UP, 2=STEP_DN, 3=SEEK
cmd_val  input  WIDTH  load value, step count, or seek target
cmd_abort  input  1  terminate the running STEP or SEEK
count  input  WIDTH  counter value, from the counter
rollover  input  1  counter all-ones flag, from the counter
load  output  WIDTH  counter load value
load_en  output  1  counter load enable
down  output  1  counter direction
busy  output  1  a command is in progress
done  output  1  one-cycle completion pulse
wrap_cnt  output  WRAPW  number of max-value passes during the current or last command

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high. While rst is high: state=IDLE, done=0, wrap_cnt=0, internal registers cleared.
- Hold rule: whenever the block is not moving the counter, it drives load_en=1, load=count, down=0. This freezes the counter, which otherwise counts every cycle. The hold outputs are combinational from the count input.
- States: IDLE, LOAD, STEP, SEEK.
- IDLE: hold outputs, cmd_ready=1, busy=0.
  - On accept: capture op and val, clear wrap_cnt.
  - LOAD goes to LOAD.
  - STEP_UP or STEP_DN with val=0: stay in IDLE, done=1 on the next cycle.
  - STEP_UP or STEP_DN with val>0: go to STEP with rem=val, dir=0 for UP and 1 for DN.
  - SEEK: go to SEEK with target=val, dir=(val<count).
- LOAD: one cycle of load_en=1, load=captured val. Go to IDLE with done=1 in the first IDLE cycle. The counter shows val in that same cycle.
- STEP: load_en=0, down=dir. rem decrements each edge. At the edge where rem==1, go to IDLE with done=1. Exactly val motion edges occur.
- SEEK: while count!=target, load_en=0 and down=dir. When count==target, drive hold outputs that cycle and go to IDLE with done=1. If the target equals count at accept, there are zero motion edges.
- Abort (STEP or SEEK only): in the cmd_abort cycle, hold outputs are driven combinationally, so no motion occurs. Go to IDLE with no done pulse. cmd_abort is ignored in IDLE and LOAD.
- Handshake:
  - cmd_ready=0 and busy=1 in LOAD, STEP and SEEK.
  - cmd_valid while busy is ignored; it is not queued.
  - Back-to-back commands are allowed: accept may occur in the same cycle as done.
- wrap_cnt increments at each edge where state is STEP or SEEK, load_en=0 and rollover=1. It saturates at 2^WRAPW-1 and holds its value after done until the next accept.
- done is registered, exactly one cycle per completed command, and 0 after an abort.
- Width rules: step count and target are WIDTH bits. Step wrap-around is the counter's own modular behaviour, so STEP_UP 3 from max gives 2.

Decomposition:
- Package counter_drv_pkg:
  - op_e enum (LOAD, STEP_UP, STEP_DN, SEEK).
  - state_e enum (IDLE, LOAD, STEP, SEEK).
  - Op encoding constants.
- No sub-module. A single FSM with rem, target and wrap registers.

Test Plan (WIDTH=4, with the counter attached):
- Reset then release with count=0 -> load_en=1, load=0, cmd_ready=1, done=0; count stays 0x0 for 10 cycles.
- LOAD 0x9 -> one cycle of load_en=1, load=0x9; count=0x9 and done=1 in the same next cycle; count then stays 0x9.
- After LOAD 0xE, STEP_UP 3 -> count E,F,0,1, then holds at 0x1; done once; wrap_cnt=1; cmd_ready=0 for the 3 motion cycles.
- SEEK 0x2 from 0x7 -> down=1, count 7,6,5,4,3,2, then holds; 5 motion edges, done=1; SEEK 0x2 again -> done with zero motion.
- STEP_DN 0 -> done the next cycle, no count change. cmd_valid asserted during a busy STEP -> not accepted, ignored.
- STEP_UP 10 from 0x0, cmd_abort after 4 motion cycles -> count holds 0x4, no done, cmd_ready=1. rst pulsed mid-SEEK -> immediate IDLE, wrap_cnt=0.

Source files
------------

// File: rtl/counter_drv_pkg.sv
// Shared types for the up/down counter sequence driver.
//   op_e    : command opcodes carried on cmd_op
//   state_e : driver FSM states
package counter_drv_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_STEP_UP = 2'd1,
    OP_STEP_DN = 2'd2,
    OP_SEEK    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_STEP = 2'd2,
    ST_SEEK = 2'd3
  } state_e;

endpackage

// File: rtl/counter_seq_drv.sv
// Command-driven controller for a free-running up/down counter.
// Accepts LOAD / STEP_UP / STEP_DN / SEEK over a valid/ready handshake and
// drives the counter's load, load_en and down inputs. Whenever the counter is
// not meant to move, it is frozen by reloading its own value (load=count).
// Ports:
//   clk, rst                  clock, async active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op, cmd_val           opcode and operand (load value / steps / target)
//   cmd_abort                 stop a running STEP or SEEK without done
//   count, rollover           observed counter value and all-ones flag
//   load, load_en, down       counter control outputs
//   busy, done                command in progress / one-cycle completion
//   wrap_cnt                  max-value passes during current/last command
module counter_seq_drv
  import counter_drv_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WRAPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_val,
  input  logic             cmd_abort,
  input  logic [WIDTH-1:0] count,
  input  logic             rollover,
  output logic [WIDTH-1:0] load,
  output logic             load_en,
  output logic             down,
  output logic             busy,
  output logic             done,
  output logic [WRAPW-1:0] wrap_cnt
);

  state_e           state_q, state_d;
  // val_q holds the load value, the remaining step count, or the seek target
  logic [WIDTH-1:0] val_q, val_d;
  logic             dir_q, dir_d;
  logic [WRAPW-1:0] wrap_q, wrap_d;
  logic             done_q, done_d;
  op_e              op;

  assign op = op_e'(cmd_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    dir_d     = dir_q;
    wrap_d    = wrap_q;
    done_d    = 1'b0;
    load      = count;
    load_en   = 1'b1;
    down      = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          wrap_d = '0;
          val_d  = cmd_val;
          unique case (op)
            OP_LOAD: begin
              dir_d   = 1'b0;
              state_d = ST_LOAD;
            end
            OP_STEP_UP, OP_STEP_DN: begin
              dir_d = (op == OP_STEP_DN);
              // Zero-length step completes without ever leaving IDLE
              if (cmd_val == '0) done_d = 1'b1;
              else               state_d = ST_STEP;
            end
            OP_SEEK: begin
              dir_d   = (cmd_val < count);
              state_d = ST_SEEK;
            end
            default: ;
          endcase
        end
      end

      ST_LOAD: begin
        load    = val_q;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      ST_STEP: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
        end else begin
          load_en = 1'b0;
          down    = dir_q;
          val_d   = val_q - WIDTH'(1);
          if (rollover && (wrap_q != '1)) wrap_d = wrap_q + WRAPW'(1);
          if (val_q == WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_SEEK: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
        end else if (count == val_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          load_en = 1'b0;
          down    = dir_q;
          if (rollover && (wrap_q != '1)) wrap_d = wrap_q + WRAPW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign done     = done_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_counter_seq_drv.sv
module tb_counter_seq_drv;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_val;
  logic       cmd_abort;
  logic [3:0] cnt;
  logic       rollover;
  logic [3:0] load;
  logic       load_en;
  logic       down;
  logic       busy;
  logic       done;
  logic [7:0] wrap_cnt;

  typedef struct packed {
    logic [3:0] cnt;
    logic [7:0] wrap;
  } exp_t;

  typedef struct {
    logic [3:0] cnt;
    logic [7:0] wrap;
    int         motion;
  } mres_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   motion_total = 0;

  counter_seq_drv #(.WIDTH(4), .WRAPW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_val(cmd_val), .cmd_abort(cmd_abort),
    .count(cnt), .rollover(rollover),
    .load(load), .load_en(load_en), .down(down),
    .busy(busy), .done(done), .wrap_cnt(wrap_cnt)
  );

  // Attached free-running up/down counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= 4'h0;
    else if (load_en) cnt <= load;
    else if (down)    cnt <= cnt - 4'd1;
    else              cnt <= cnt + 4'd1;
  end
  assign rollover = &cnt;

  always @(posedge clk) if (!rst && !load_en) motion_total <= motion_total + 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic mres_t model_step(input logic [3:0] c0, input logic [3:0] n, input bit dn);
    mres_t r;
    logic [3:0] c;
    c = c0; r.wrap = 8'h0; r.motion = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (c == 4'hF && r.wrap != 8'hFF) r.wrap++;
      c = dn ? c - 4'd1 : c + 4'd1;
      r.motion++;
    end
    r.cnt = c;
    return r;
  endfunction

  function automatic mres_t model_seek(input logic [3:0] c0, input logic [3:0] t);
    mres_t r;
    logic [3:0] c;
    bit dn;
    c = c0; r.wrap = 8'h0; r.motion = 0; dn = (t < c0);
    while (c != t) begin
      if (c == 4'hF && r.wrap != 8'hFF) r.wrap++;
      c = dn ? c - 4'd1 : c + 4'd1;
      r.motion++;
    end
    r.cnt = c;
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [3:0] v);
    cmd_op = op; cmd_val = v; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit got, output int ncyc, output int nstall);
    got = 1'b0; ncyc = 0; nstall = 0;
    while (!got && ncyc < limit) begin
      @(negedge clk);
      ncyc++;
      if (done) got = 1'b1;
      else if (!cmd_ready) nstall++;
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_val = 4'h0; cmd_abort = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (load_en !== 1'b1) begin n_fail++; $display("FAIL rst_load_en: got %b want 1", load_en); end
    n_cmp++; if (load !== 4'h0) begin n_fail++; $display("FAIL rst_load: got %h want 0", load); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_done_busy: got %b%b want 00", done, busy); end
    n_cmp++; if (wrap_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_wrap: got %h want 0", wrap_cnt); end
    @(negedge clk) rst = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cnt !== 4'h0 || done !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL idle_hold: got count %h done %b want count 0 held, done 0", cnt, done); end
  endtask

  task automatic test_load();
    bit got; int nc, ns; exp_t e;
    @(negedge clk);
    sb.push_back(exp_t'{cnt: 4'h9, wrap: 8'h0});
    issue(2'd0, 4'h9);
    @(negedge clk);
    n_cmp++; if (load_en !== 1'b1 || load !== 4'h9) begin n_fail++; $display("FAIL load_drive: got en %b load %h want en 1 load 9", load_en, load); end
    n_cmp++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL load_busy: got busy %b ready %b want 1 0", busy, cmd_ready); end
    wait_done(10, got, nc, ns);
    n_cmp++; if (!got || nc != 1) begin n_fail++; $display("FAIL load_done_timing: got done %b after %0d want done after 1", got, nc); end
    e = sb.pop_front();
    n_cmp++; if (cnt !== e.cnt || wrap_cnt !== e.wrap) begin n_fail++; $display("FAIL load_result: got %h/%h want %h/%h", cnt, wrap_cnt, e.cnt, e.wrap); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || cnt !== 4'h9) begin n_fail++; $display("FAIL load_after: got done %b count %h want 0 9", done, cnt); end
  endtask

  task automatic test_step_up();
    bit got; int nc, ns, m0; exp_t e; mres_t m;
    sb.push_back(exp_t'{cnt: 4'hE, wrap: 8'h0});
    issue(2'd0, 4'hE);
    wait_done(10, got, nc, ns);
    e = sb.pop_front();
    n_cmp++; if (!got || cnt !== e.cnt) begin n_fail++; $display("FAIL preload_E: got done %b count %h want 1 %h", got, cnt, e.cnt); end
    m = model_step(4'hE, 4'd3, 1'b0);
    sb.push_back(exp_t'{cnt: m.cnt, wrap: m.wrap});
    m0 = motion_total;
    issue(2'd1, 4'd3);
    wait_done(20, got, nc, ns);
    n_cmp++; if (!got) begin n_fail++; $display("FAIL step_up_timeout: got no done want done"); end
    n_cmp++; if (ns != 3) begin n_fail++; $display("FAIL step_up_stall: got %0d want 3", ns); end
    e = sb.pop_front();
    n_cmp++; if (cnt !== e.cnt || wrap_cnt !== e.wrap) begin n_fail++; $display("FAIL step_up_result: got %h/%h want %h/%h", cnt, wrap_cnt, e.cnt, e.wrap); end
    n_cmp++; if (motion_total - m0 != m.motion) begin n_fail++; $display("FAIL step_up_motion: got %0d want %0d", motion_total - m0, m.motion); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || cnt !== m.cnt) begin n_fail++; $display("FAIL step_up_after: got done %b count %h want 0 %h", done, cnt, m.cnt); end
  endtask

  task automatic test_seek();
    bit got; int nc, ns, m0; exp_t e; mres_t m;
    sb.push_back(exp_t'{cnt: 4'h7, wrap: 8'h0});
    issue(2'd0, 4'h7);
    wait_done(10, got, nc, ns);
    e = sb.pop_front();
    n_cmp++; if (!got || cnt !== e.cnt) begin n_fail++; $display("FAIL preload_7: got done %b count %h want 1 %h", got, cnt, e.cnt); end
    m = model_seek(4'h7, 4'h2);
    sb.push_back(exp_t'{cnt: m.cnt, wrap: m.wrap});
    m0 = motion_total;
    issue(2'd3, 4'h2);
    @(negedge clk);
    n_cmp++; if (down !== 1'b1 || load_en !== 1'b0) begin n_fail++; $display("FAIL seek_dir: got down %b en %b want 1 0", down, load_en); end
    wait_done(30, got, nc, ns);
    n_cmp++; if (!got) begin n_fail++; $display("FAIL seek_timeout: got no done want done"); end
    e = sb.pop_front();
    n_cmp++; if (cnt !== e.cnt || wrap_cnt !== e.wrap) begin n_fail++; $display("FAIL seek_result: got %h/%h want %h/%h", cnt, wrap_cnt, e.cnt, e.wrap); end
    n_cmp++; if (motion_total - m0 != m.motion) begin n_fail++; $display("FAIL seek_motion: got %0d want %0d", motion_total - m0, m.motion); end
    sb.push_back(exp_t'{cnt: 4'h2, wrap: 8'h0});
    m0 = motion_total;
    issue(2'd3, 4'h2);
    wait_done(10, got, nc, ns);
    n_cmp++; if (!got) begin n_fail++; $display("FAIL seek_same_timeout: got no done want done"); end
    e = sb.pop_front();
    n_cmp++; if (cnt !== e.cnt || wrap_cnt !== e.wrap) begin n_fail++; $display("FAIL seek_same_result: got %h/%h want %h/%h", cnt, wrap_cnt, e.cnt, e.wrap); end
    n_cmp++; if (motion_total != m0) begin n_fail++; $display("FAIL seek_same_motion: got %0d want 0", motion_total - m0); end
  endtask

  task automatic test_step_zero();
    bit got; int nc, ns; exp_t e;
    sb.push_back(exp_t'{cnt: 4'h2, wrap: 8'h0});
    issue(2'd2, 4'h0);
    wait_done(5, got, nc, ns);
    n_cmp++; if (!got || nc != 1) begin n_fail++; $display("FAIL step_zero_timing: got done %b after %0d want done after 1", got, nc); end
    e = sb.pop_front();
    n_cmp++; if (cnt !== e.cnt || wrap_cnt !== e.wrap) begin n_fail++; $display("FAIL step_zero_result: got %h/%h want %h/%h", cnt, wrap_cnt, e.cnt, e.wrap); end
  endtask

  task automatic test_busy_ignored();
    bit got, bad; int nc, ns; exp_t e; mres_t m;
    m = model_step(4'h2, 4'd5, 1'b0);
    sb.push_back(exp_t'{cnt: m.cnt, wrap: m.wrap});
    issue(2'd1, 4'd5);
    @(negedge clk);
    cmd_op = 2'd0; cmd_val = 4'hA; cmd_valid = 1'b1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", cmd_ready); end
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(20, got, nc, ns);
    n_cmp++; if (!got) begin n_fail++; $display("FAIL busy_step_timeout: got no done want done"); end
    e = sb.pop_front();
    n_cmp++; if (cnt !== e.cnt || wrap_cnt !== e.wrap) begin n_fail++; $display("FAIL busy_step_result: got %h/%h want %h/%h", cnt, wrap_cnt, e.cnt, e.wrap); end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cnt !== m.cnt || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL busy_cmd_dropped: got count %h busy %b want %h 0", cnt, busy, m.cnt); end
  endtask

  task automatic test_back_to_back();
    bit got; int nc, ns; exp_t e; mres_t m;
    @(negedge clk);
    m = model_step(4'h7, 4'd2, 1'b1);
    sb.push_back(exp_t'{cnt: m.cnt, wrap: m.wrap});
    issue(2'd2, 4'd2);
    wait_done(10, got, nc, ns);
    e = sb.pop_front();
    n_cmp++; if (!got || cnt !== e.cnt) begin n_fail++; $display("FAIL b2b_first: got done %b count %h want 1 %h", got, cnt, e.cnt); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_at_done: got %b want 1", cmd_ready); end
    sb.push_back(exp_t'{cnt: 4'hC, wrap: 8'h0});
    issue(2'd0, 4'hC);
    wait_done(10, got, nc, ns);
    n_cmp++; if (!got || nc != 2) begin n_fail++; $display("FAIL b2b_second_timing: got done %b after %0d want done after 2", got, nc); end
    e = sb.pop_front();
    n_cmp++; if (cnt !== e.cnt || wrap_cnt !== e.wrap) begin n_fail++; $display("FAIL b2b_second_result: got %h/%h want %h/%h", cnt, wrap_cnt, e.cnt, e.wrap); end
  endtask

  task automatic test_abort();
    bit got, bad; int nc, ns, m0; exp_t e;
    sb.push_back(exp_t'{cnt: 4'h0, wrap: 8'h0});
    issue(2'd0, 4'h0);
    wait_done(10, got, nc, ns);
    e = sb.pop_front();
    n_cmp++; if (!got || cnt !== e.cnt) begin n_fail++; $display("FAIL preload_0: got done %b count %h want 1 %h", got, cnt, e.cnt); end
    m0 = motion_total;
    issue(2'd1, 4'd10);
    repeat (5) @(negedge clk);
    n_cmp++; if (cnt !== 4'h4) begin n_fail++; $display("FAIL abort_precount: got %h want 4", cnt); end
    cmd_abort = 1'b1;
    #1;
    n_cmp++; if (load_en !== 1'b1 || load !== 4'h4) begin n_fail++; $display("FAIL abort_hold: got en %b load %h want 1 4", load_en, load); end
    @(posedge clk);
    #1 cmd_abort = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || cnt !== 4'h4) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL abort_no_done: got done %b count %h want 0 4", done, cnt); end
    n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got ready %b busy %b want 1 0", cmd_ready, busy); end
    n_cmp++; if (motion_total - m0 != 4) begin n_fail++; $display("FAIL abort_motion: got %0d want 4", motion_total - m0); end
  endtask

  task automatic test_reset_mid_seek();
    bit got, bad; int nc, ns; exp_t e;
    sb.push_back(exp_t'{cnt: 4'hF, wrap: 8'h0});
    issue(2'd0, 4'hF);
    wait_done(10, got, nc, ns);
    e = sb.pop_front();
    n_cmp++; if (!got || cnt !== e.cnt) begin n_fail++; $display("FAIL preload_F: got done %b count %h want 1 %h", got, cnt, e.cnt); end
    issue(2'd3, 4'h3);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (wrap_cnt !== 8'h1 || busy !== 1'b1) begin n_fail++; $display("FAIL seek_wrap_pre_rst: got wrap %h busy %b want 1 1", wrap_cnt, busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || load_en !== 1'b1) begin n_fail++; $display("FAIL mid_rst_idle: got busy %b ready %b en %b want 0 1 1", busy, cmd_ready, load_en); end
    n_cmp++; if (wrap_cnt !== 8'h0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_regs: got wrap %h done %b want 0 0", wrap_cnt, done); end
    @(negedge clk) rst = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || cnt !== 4'h0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL post_rst_hold: got count %h busy %b done %b want 0 0 0", cnt, busy, done); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_step_up();
    test_seek();
    test_step_zero();
    test_busy_ignored();
    test_back_to_back();
    test_abort();
    test_reset_mid_seek();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
